// File: rtl/fg_island_prog_sequencer.sv
// Programming sequencer for one floating-gate island: takes one command at a time, drives the
// column/row decoders, issues a train of timed inject/tunnel/measure pulses and reports status.
module fg_island_prog_sequencer #(
  parameter int unsigned H_BITS    = 4,
  parameter int unsigned V_BITS    = 3,
  parameter int unsigned NUM_COLS  = 10,
  parameter int unsigned NUM_ROWS  = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TIM_W     = 16,
  parameter int unsigned SETUP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [H_BITS-1:0] cmd_col,
  input  logic [V_BITS-1:0] cmd_row,
  input  logic [1:0]        cmd_mode,
  input  logic [CNT_W-1:0]  cmd_pulses,
  input  logic [TIM_W-1:0]  cmd_width,
  input  logic [TIM_W-1:0]  cmd_gap,
  input  logic              abort,
  output logic [H_BITS-1:0] h_addr,
  output logic              h_en,
  output logic [V_BITS-1:0] v_addr,
  output logic              v_en,
  output logic              inj_pulse,
  output logic              tun_pulse,
  output logic              meas_en,
  output logic              busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [CNT_W-1:0]  rsp_count
);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StGap, StRelease, StResp} state_e;

  localparam logic [1:0] ModeInj     = 2'b00;
  localparam logic [1:0] ModeTun     = 2'b01;
  localparam logic [1:0] ModeMeas    = 2'b10;
  localparam logic [1:0] ModeRsvd    = 2'b11;
  localparam logic [1:0] StatOk      = 2'b00;
  localparam logic [1:0] StatAbort   = 2'b01;
  localparam logic [1:0] StatBadAddr = 2'b10;
  localparam logic [1:0] StatBadCmd  = 2'b11;
  localparam logic [TIM_W-1:0] SetupLoad = TIM_W'(SETUP_CYC - 1);

  state_e           state_q;
  logic [1:0]       mode_q, status_q;
  logic [CNT_W-1:0] pulses_q, cnt_q, cnt_inc;
  logic [TIM_W-1:0] width_q, gap_q, timer_q;
  logic [TIM_W-1:0] timer_dec, width_load, gap_load;
  logic             bad_addr, bad_cmd, last_pulse, timer_done, abortable;
  logic             sel_inj, sel_tun, sel_meas;

  always_comb begin
    bad_addr   = (32'(cmd_col) >= NUM_COLS) || (32'(cmd_row) >= NUM_ROWS);
    bad_cmd    = (cmd_mode == ModeRsvd) || (cmd_pulses == '0) || (cmd_width == '0);
    cnt_inc    = cnt_q + CNT_W'(1);
    last_pulse = (cnt_inc == pulses_q);
    timer_done = (timer_q == '0);
    timer_dec  = timer_q - TIM_W'(1);
    width_load = width_q - TIM_W'(1);
    gap_load   = gap_q - TIM_W'(1);
    abortable  = (state_q == StSetup) || (state_q == StPulse) || (state_q == StGap);
    sel_inj    = (mode_q == ModeInj);
    sel_tun    = (mode_q == ModeTun);
    sel_meas   = (mode_q == ModeMeas);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      status_q   <= StatOk;
      pulses_q   <= '0;
      cnt_q      <= '0;
      width_q    <= '0;
      gap_q      <= '0;
      timer_q    <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      h_addr     <= '0;
      h_en       <= 1'b0;
      v_addr     <= '0;
      v_en       <= 1'b0;
      inj_pulse  <= 1'b0;
      tun_pulse  <= 1'b0;
      meas_en    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_count  <= '0;
    end else if (abort && abortable) begin
      // A partial pulse is dropped and not counted; enables stay up for the release cycle.
      state_q   <= StRelease;
      status_q  <= StatAbort;
      inj_pulse <= 1'b0;
      tun_pulse <= 1'b0;
      meas_en   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            mode_q    <= cmd_mode;
            pulses_q  <= cmd_pulses;
            width_q   <= cmd_width;
            gap_q     <= cmd_gap;
            cnt_q     <= '0;
            cmd_ready <= 1'b0;
            if (bad_addr || bad_cmd) begin
              state_q    <= StResp;
              rsp_valid  <= 1'b1;
              rsp_status <= bad_addr ? StatBadAddr : StatBadCmd;
              rsp_count  <= '0;
            end else begin
              state_q <= StSetup;
              busy    <= 1'b1;
              h_addr  <= cmd_col;
              v_addr  <= cmd_row;
              h_en    <= 1'b1;
              v_en    <= 1'b1;
              timer_q <= SetupLoad;
            end
          end
        end
        StSetup, StGap: begin
          if (timer_done) begin
            state_q   <= StPulse;
            timer_q   <= width_load;
            inj_pulse <= sel_inj;
            tun_pulse <= sel_tun;
            meas_en   <= sel_meas;
          end else begin
            timer_q <= timer_dec;
          end
        end
        StPulse: begin
          if (timer_done) begin
            cnt_q <= cnt_inc;
            if (last_pulse || gap_q != '0) begin
              state_q   <= last_pulse ? StRelease : StGap;
              status_q  <= StatOk;
              timer_q   <= gap_load;
              inj_pulse <= 1'b0;
              tun_pulse <= 1'b0;
              meas_en   <= 1'b0;
            end else begin
              // Zero gap: reload and keep the pulse output high for a back-to-back pulse.
              timer_q <= width_load;
            end
          end else begin
            timer_q <= timer_dec;
          end
        end
        StRelease: begin
          state_q    <= StResp;
          busy       <= 1'b0;
          h_en       <= 1'b0;
          v_en       <= 1'b0;
          h_addr     <= '0;
          v_addr     <= '0;
          rsp_valid  <= 1'b1;
          rsp_status <= status_q;
          rsp_count  <= cnt_q;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q    <= StIdle;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_count  <= '0;
            cmd_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
